// File: rtl/dds_sweep_ctrl_if.sv
// Configuration handshake bundle for dds_sweep_ctrl: sweep parameters offered with valid/ready.
interface dds_sweep_ctrl_if #(
  parameter int KW_WIDTH    = 28,
  parameter int DWELL_WIDTH = 16
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [KW_WIDTH-1:0]    cfg_start;
  logic [KW_WIDTH-1:0]    cfg_stop;
  logic [KW_WIDTH-1:0]    cfg_step;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic                   cfg_cont;

  modport master (output cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_cont,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_cont,
                  output cfg_ready);
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep controller driving the DDS tuning word KW (sawtooth by default).
// Define SWEEP_BIDIR_EN for a triangle sweep (up leg then down leg back to start).
module dds_sweep_ctrl #(
  parameter int KW_WIDTH    = 28,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  dds_sweep_ctrl_if.slave     cfg,
  input  logic                run,
  input  logic                abort,
  output logic [KW_WIDTH-1:0] KW,
  output logic                kw_upd,
  output logic                busy,
  output logic                done
);
  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                 st, st_n;
  logic                   dir, dir_n, loaded, loaded_n, cont_r, cont_n;
  logic                   kw_upd_n, done_n;
  logic [KW_WIDTH-1:0]    kw_n, start_r, start_n, stop_r, stop_n, step_r, step_n;
  logic [DWELL_WIDTH-1:0] dwell_r, dwell_n, cnt, cnt_n;
  logic [KW_WIDTH:0]      up_sum, dn_diff;
  logic [KW_WIDTH-1:0]    up_nxt, dn_nxt;
  logic                   up_end;
`ifdef SWEEP_BIDIR_EN
  logic                   dn_end;
`endif

  assign cfg.cfg_ready = (st == IDLE);

  // One extra bit so a carry/borrow clamps to the endpoint instead of wrapping.
  assign up_sum  = {1'b0, KW} + {1'b0, step_r};
  assign dn_diff = {1'b0, KW} - {1'b0, step_r};
  assign up_nxt  = (up_sum >= {1'b0, stop_r}) ? stop_r : up_sum[KW_WIDTH-1:0];
  assign dn_nxt  = (dn_diff[KW_WIDTH] || (dn_diff[KW_WIDTH-1:0] <= start_r)) ? start_r
                                                                             : dn_diff[KW_WIDTH-1:0];
  assign up_end  = !dir && (KW == stop_r);
`ifdef SWEEP_BIDIR_EN
  assign dn_end  = dir && (KW == start_r);
`endif

  always_comb begin
    st_n     = st;
    dir_n    = dir;
    loaded_n = loaded;
    cont_n   = cont_r;
    kw_n     = KW;
    kw_upd_n = 1'b0;
    done_n   = 1'b0;
    cnt_n    = cnt;
    start_n  = start_r;
    stop_n   = stop_r;
    step_n   = step_r;
    dwell_n  = dwell_r;
    // abort also blocks a config offered in the same cycle, even though cfg_ready is high.
    if (abort) begin
      st_n     = IDLE;
      kw_n     = start_r;
      kw_upd_n = (KW != start_r);
      dir_n    = 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (cfg.cfg_valid) begin
            start_n  = cfg.cfg_start;
            stop_n   = (cfg.cfg_stop > cfg.cfg_start) ? cfg.cfg_stop : cfg.cfg_start;
            step_n   = (cfg.cfg_step == '0) ? KW_WIDTH'(1) : cfg.cfg_step;
            dwell_n  = (cfg.cfg_dwell == '0) ? DWELL_WIDTH'(1) : cfg.cfg_dwell;
            cont_n   = cfg.cfg_cont;
            kw_n     = cfg.cfg_start;
            kw_upd_n = 1'b1;
            loaded_n = 1'b1;
          end else if (run && loaded) begin
            st_n  = SWEEP;
            cnt_n = dwell_r - DWELL_WIDTH'(1);
            dir_n = 1'b0;
          end
        end
        SWEEP: begin
          if (run) begin
            if (cnt != '0) begin
              cnt_n = cnt - DWELL_WIDTH'(1);
            end else begin
              cnt_n    = dwell_r - DWELL_WIDTH'(1);
              kw_upd_n = 1'b1;
`ifdef SWEEP_BIDIR_EN
              // Turnaround steps straight off the endpoint so it is held only once.
              if ((up_end && (KW == start_r)) || dn_end) begin
                if (cont_r) begin
                  dir_n = 1'b0;
                  kw_n  = up_nxt;
                end else begin
                  st_n     = IDLE;
                  done_n   = 1'b1;
                  kw_upd_n = 1'b0;
                end
              end else if (up_end) begin
                dir_n = 1'b1;
                kw_n  = dn_nxt;
              end else begin
                kw_n = dir ? dn_nxt : up_nxt;
              end
`else
              if (up_end) begin
                if (cont_r) begin
                  kw_n = start_r;
                end else begin
                  st_n     = IDLE;
                  done_n   = 1'b1;
                  kw_upd_n = 1'b0;
                end
              end else begin
                kw_n = up_nxt;
              end
`endif
            end
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      dir     <= 1'b0;
      loaded  <= 1'b0;
      cont_r  <= 1'b0;
      KW      <= '0;
      kw_upd  <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      cnt     <= '0;
      start_r <= '0;
      stop_r  <= '0;
      step_r  <= '0;
      dwell_r <= '0;
    end else begin
      st      <= st_n;
      dir     <= dir_n;
      loaded  <= loaded_n;
      cont_r  <= cont_n;
      KW      <= kw_n;
      kw_upd  <= kw_upd_n;
      done    <= done_n;
      busy    <= (st_n == SWEEP);
      cnt     <= cnt_n;
      start_r <= start_n;
      stop_r  <= stop_n;
      step_r  <= step_n;
      dwell_r <= dwell_n;
    end
  end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Randomised + directed bench for dds_sweep_ctrl against a value-list sweep model.
module tb_dds_sweep_ctrl;
  localparam int KW = 28;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          abort = 1'b0;
  logic [KW-1:0] kw;
  logic          kw_upd, busy, done;
  int            n_chk = 0;
  int            n_fail = 0;
  bit            bidir;
  logic [KW-1:0] tr_kw[$];
  bit            tr_upd[$];

  dds_sweep_ctrl_if #(.KW_WIDTH(KW), .DWELL_WIDTH(DW)) cif();

  dds_sweep_ctrl #(.KW_WIDTH(KW), .DWELL_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cif.slave), .run(run), .abort(abort),
    .KW(kw), .kw_upd(kw_upd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Expected per-cycle KW trace: list the visited values, then hold each for dwell clocks.
  task automatic build_trace(input longint s, input longint e, input longint p, input longint d,
                             input bit cont, input int ncyc);
    longint se, sp, de, v;
    longint per[$];
    int i;
    se = (e > s) ? e : s;
    sp = (p == 0) ? 1 : p;
    de = (d == 0) ? 1 : d;
    v = s;
    forever begin
      per.push_back(v);
      if (v == se) break;
      v = (v + sp > se) ? se : v + sp;
    end
    if (bidir && se != s) begin
      v = se;
      forever begin
        v = (v - sp < s) ? s : v - sp;
        if (v == s) break;
        per.push_back(v);
      end
      if (!cont) per.push_back(s);
    end
    tr_kw.delete();
    tr_upd.delete();
    i = 0;
    while (cont ? (tr_kw.size() < ncyc) : (i < per.size())) begin
      for (int j = 0; j < de; j++) begin
        tr_kw.push_back(KW'(per[i % per.size()]));
        tr_upd.push_back(j == 0 && i > 0);
      end
      i++;
    end
  endtask

  task automatic do_sweep(input string tag, input logic [KW-1:0] s, input logic [KW-1:0] e,
                          input logic [KW-1:0] p, input logic [DW-1:0] d, input bit cont,
                          input bit run_with_cfg, input bit noise, input int pause_at,
                          input int abort_at, input int ncyc);
    int last;
    build_trace(s, e, p, d, cont, ncyc);
    last = (abort_at >= 0) ? abort_at : tr_kw.size() - 1;
    @(negedge clk);
    cif.cfg_valid = 1'b1; cif.cfg_start = s; cif.cfg_stop = e; cif.cfg_step = p;
    cif.cfg_dwell = d; cif.cfg_cont = cont; run = run_with_cfg;
    @(negedge clk);
    cif.cfg_valid = 1'b0; run = 1'b1;
    n_chk++; if (kw !== s) begin n_fail++; $display("FAIL %s accept kw: got %h want %h", tag, kw, s); end
    n_chk++; if (kw_upd !== 1'b1) begin n_fail++; $display("FAIL %s accept kw_upd: got %b want 1", tag, kw_upd); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s accept busy: got %b want 0", tag, busy); end
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      n_chk++; if (kw !== tr_kw[k]) begin n_fail++; $display("FAIL %s kw cyc %0d: got %h want %h", tag, k, kw, tr_kw[k]); end
      n_chk++; if (kw_upd !== tr_upd[k]) begin n_fail++; $display("FAIL %s kw_upd cyc %0d: got %b want %b", tag, k, kw_upd, tr_upd[k]); end
      n_chk++; if (busy !== 1'b1 || done !== 1'b0 || cif.cfg_ready !== 1'b0) begin
        n_fail++; $display("FAIL %s status cyc %0d: busy/done/rdy got %b%b%b want 100", tag, k, busy, done, cif.cfg_ready);
      end
      if (noise && k == 0) begin
        cif.cfg_valid = 1'b1; cif.cfg_start = KW'($urandom); cif.cfg_stop = KW'($urandom);
        cif.cfg_step = KW'($urandom); cif.cfg_dwell = DW'($urandom); cif.cfg_cont = 1'b1;
      end
      if (k == last) begin
        cif.cfg_valid = 1'b0;
        if (abort_at >= 0) begin
          abort = 1'b1;
          @(negedge clk);
          n_chk++; if (busy !== 1'b0 || cif.cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s abort status: busy/rdy got %b%b want 01", tag, busy, cif.cfg_ready);
          end
          n_chk++; if (kw !== s) begin n_fail++; $display("FAIL %s abort kw: got %h want %h", tag, kw, s); end
          n_chk++; if (kw_upd !== (tr_kw[k] != s)) begin
            n_fail++; $display("FAIL %s abort kw_upd: got %b want %b", tag, kw_upd, tr_kw[k] != s);
          end
          abort = 1'b0; run = 1'b0;
        end
      end else if (k == pause_at) begin
        run = 1'b0;
        repeat (5) begin
          @(negedge clk);
          n_chk++; if (kw !== tr_kw[k] || kw_upd !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL %s pause: kw/upd/busy got %h %b %b want %h 0 1", tag, kw, kw_upd, busy, tr_kw[k]);
          end
        end
        run = 1'b1;
      end
    end
    if (abort_at < 0) begin
      @(negedge clk);
      run = 1'b0;
      n_chk++; if (busy !== 1'b0 || done !== 1'b1 || cif.cfg_ready !== 1'b1) begin
        n_fail++; $display("FAIL %s end status: busy/done/rdy got %b%b%b want 011", tag, busy, done, cif.cfg_ready);
      end
      n_chk++; if (kw !== tr_kw[last] || kw_upd !== 1'b0) begin
        n_fail++; $display("FAIL %s end kw: got %h/%b want %h/0", tag, kw, kw_upd, tr_kw[last]);
      end
      @(negedge clk);
      n_chk++; if (done !== 1'b0 || busy !== 1'b0 || kw !== tr_kw[last]) begin
        n_fail++; $display("FAIL %s post: done/busy/kw got %b%b %h want 00 %h", tag, done, busy, kw, tr_kw[last]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++; if (kw !== '0 || kw_upd !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cif.cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset: kw/upd/busy/done/rdy got %h %b%b%b%b want 0 0001", kw, kw_upd, busy, done, cif.cfg_ready);
    end
    rst_n = 1'b1;
    run = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_chk++; if (busy !== 1'b0 || kw !== '0) begin
        n_fail++; $display("FAIL run_unloaded: busy/kw got %b %h want 0 0", busy, kw);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_single_up();
    do_sweep("single_up", 28'd100, 28'd130, 28'd10, 16'd3, 1'b0, 1'b0, 1'b0, -1, -1, 0);
  endtask

  task automatic test_overshoot();
    do_sweep("overshoot", 28'd0, 28'd25, 28'd10, 16'd2, 1'b0, 1'b0, 1'b0, -1, -1, 0);
    do_sweep("overflow", 28'hFFFFFF0, 28'hFFFFFFF, 28'h20, 16'd2, 1'b0, 1'b0, 1'b0, -1, -1, 0);
  endtask

  task automatic test_continuous();
    do_sweep("continuous", 28'd0, 28'd25, 28'd10, 16'd1, 1'b1, 1'b0, 1'b0, -1, 19, 20);
  endtask

  task automatic test_pause_abort();
    do_sweep("pause", 28'd0, 28'd200, 28'd7, 16'd6, 1'b0, 1'b0, 1'b0, 20, -1, 0);
    do_sweep("abort", 28'd100, 28'd500, 28'd30, 16'd2, 1'b0, 1'b0, 1'b0, 3, 9, 0);
  endtask

  task automatic test_degenerate();
    do_sweep("degenerate", 28'd50, 28'd40, 28'd0, 16'd0, 1'b0, 1'b0, 1'b0, -1, -1, 0);
  endtask

  task automatic test_handshake();
    do_sweep("cfg_while_busy", 28'd1000, 28'd1100, 28'd25, 16'd2, 1'b0, 1'b0, 1'b1, -1, -1, 0);
    do_sweep("cfg_with_run", 28'd7, 28'd40, 28'd11, 16'd2, 1'b0, 1'b1, 1'b0, -1, -1, 0);
  endtask

  task automatic test_random();
    logic [KW-1:0] s, e, p;
    logic [DW-1:0] d;
    for (int i = 0; i < 12; i++) begin
      s = KW'($urandom);
      e = s + KW'($urandom_range(0, 150));
      p = ($urandom_range(0, 3) == 0) ? '0 : KW'($urandom_range(1, 40));
      d = DW'($urandom_range(0, 3));
      do_sweep("random", s, e, p, d, 1'b0, 1'(($urandom_range(0, 1))), 1'b0, -1, -1, 0);
    end
  endtask

  initial begin
`ifdef SWEEP_BIDIR_EN
    bidir = 1'b1;
`else
    bidir = 1'b0;
`endif
    cif.cfg_valid = 1'b0; cif.cfg_start = '0; cif.cfg_stop = '0;
    cif.cfg_step = '0; cif.cfg_dwell = '0; cif.cfg_cont = 1'b0;
    test_reset();
    test_single_up();
    test_overshoot();
    test_continuous();
    test_pause_abort();
    test_degenerate();
    test_handshake();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
